// File: rtl/fwvip_wb_target_mem.sv
// Wishbone classic target over a word-addressed RAM; ack/err arrive wait_cfg+1 cycles after accept.
// One transfer in flight; dropping cyc during wait states abandons the transfer without a response.
module fwvip_wb_target_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   adr,
  input  logic [DATA_WIDTH-1:0]   dat_w,
  output logic [DATA_WIDTH-1:0]   dat_r,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] sel,
  output logic                    ack,
  output logic                    err,
  input  logic [3:0]              wait_cfg,
  output logic [15:0]             ack_cnt,
  output logic [15:0]             err_cnt
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int OFF_LSB = $clog2(BYTES);
  localparam int IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] WIN_BYTES = (ADDR_WIDTH+1)'(DEPTH_WORDS * BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic                    we_q;
  logic [BYTES-1:0]        sel_q;
  logic [3:0]              wcnt_q;
  logic                    accept;
  logic                    resp;
  logic [ADDR_WIDTH-1:0]   offset;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;
  logic                    wr_commit;
  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    resp    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cyc && stb) begin
          accept  = 1'b1;
          state_d = (wait_cfg != 4'd0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!cyc)                state_d = IDLE;
        else if (wcnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        resp    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Window check is done on the captured address so the decode never sees a live bus.
  assign offset    = adr_q - BASE_ADDR;
  assign in_range  = (adr_q >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
  assign idx       = offset[OFF_LSB +: IDX_W];
  assign wr_commit = resp && in_range && we_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        adr_q  <= adr;
        dat_q  <= dat_w;
        we_q   <= we;
        sel_q  <= sel;
        wcnt_q <= wait_cfg;
      end else if (state_q == WAIT) begin
        wcnt_q <= wcnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_commit) begin
      for (int i = 0; i < BYTES; i++) begin
        if (sel_q[i]) mem[idx][i*8 +: 8] <= dat_q[i*8 +: 8];
      end
    end
  end

  // Termination is registered off the RESP state, giving the extra cycle of latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack     <= 1'b0;
      err     <= 1'b0;
      dat_r   <= '0;
      ack_cnt <= '0;
      err_cnt <= '0;
    end else begin
      ack   <= resp && in_range;
      err   <= resp && !in_range;
      dat_r <= (resp && in_range && !we_q) ? mem[idx] : '0;
      if (ack && (ack_cnt != 16'hFFFF)) ack_cnt <= ack_cnt + 16'd1;
      if (err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwvip_wb_target_mem.sv
// Directed bench for fwvip_wb_target_mem; expected responses are queued at issue and
// compared by an independent monitor whenever ack or err is seen.
module tb_fwvip_wb_target_mem;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          RESP_LIMIT = 40;

  logic        clock;
  logic        reset_n;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic        ack;
  logic        err;
  logic [3:0]  wait_cfg;
  logic [15:0] ack_cnt;
  logic [15:0] err_cnt;

  typedef struct {
    logic        is_err;
    logic [31:0] dat;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;

  fwvip_wb_target_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (BASE)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .adr     (adr),
    .dat_w   (dat_w),
    .dat_r   (dat_r),
    .cyc     (cyc),
    .stb     (stb),
    .we      (we),
    .sel     (sel),
    .ack     (ack),
    .err     (err),
    .wait_cfg(wait_cfg),
    .ack_cnt (ack_cnt),
    .err_cnt (err_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every termination must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n) begin
      if (ack || err) begin
        chk("ack_err_exclusive", 32'(ack & err), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual ack=%b err=%b required none", ack, err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_is_err", 32'(err), 32'(e.is_err));
          chk("resp_dat_r", dat_r, e.dat);
          chk("resp_latency", 32'(cyc_cnt - e.acc), 32'(e.lat));
        end
      end else if (dat_r != 32'd0) begin
        chk("dat_r_idle", dat_r, 32'd0);
      end
    end
  end

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [3:0] wc,
                      input logic ee, input logic [31:0] ed);
    exp_t e;
    int   n;
    @(negedge clock);
    wait_cfg = wc; adr = a; dat_w = d; we = w; sel = s; cyc = 1'b1; stb = 1'b1;
    e.is_err = ee; e.dat = ed; e.acc = cyc_cnt + 1; e.lat = int'(wc) + 1;
    exp_q.push_back(e);
    @(negedge clock);
    stb = 1'b0;
    n = 0;
    while (!(ack || err) && n < RESP_LIMIT) begin
      @(negedge clock);
      n++;
    end
    if (n >= RESP_LIMIT) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout actual no response after %0d cycles required ack/err", n);
    end
    cyc = 1'b0;
  endtask

  task automatic start_long_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    wait_cfg = 4'd5; adr = a; dat_w = d; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(negedge clock);
    stb = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat_w = '0; sel = '0; wait_cfg = '0;
    repeat (3) @(negedge clock);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dat_r", dat_r, 32'd0);
    chk("rst_ack_cnt", 32'(ack_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    reset_n = 1'b1;

    // Zero wait states: write then read back.
    xfer(1'b1, BASE + 32'h8, 32'hA5A5_5A5A, 4'hF, 4'd0, 1'b0, 32'h0);
    xfer(1'b0, BASE + 32'h8, 32'h0,        4'hF, 4'd0, 1'b0, 32'hA5A5_5A5A);

    // Byte-lane merge.
    xfer(1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF,    4'd0, 1'b0, 32'h0);
    xfer(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'b0101, 4'd0, 1'b0, 32'h0);
    xfer(1'b0, BASE + 32'h20, 32'h0,         4'hF,    4'd0, 1'b0, 32'h11FF_33FF);
    @(negedge clock);
    chk("ack_cnt_t2", 32'(ack_cnt), 32'd5);

    // Three wait states.
    xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, 4'd3, 1'b0, 32'hA5A5_5A5A);

    // Out-of-window accesses on both sides, plus an aliasing write that must not land.
    xfer(1'b0, BASE + 32'h1000, 32'h0,         4'hF, 4'd0, 1'b1, 32'h0);
    xfer(1'b0, BASE - 32'h4,    32'h0,         4'hF, 4'd0, 1'b1, 32'h0);
    xfer(1'b1, BASE + 32'h1008, 32'hDEAD_BEEF, 4'hF, 4'd0, 1'b1, 32'h0);
    xfer(1'b1, BASE + 32'h8,    32'h0,         4'h0, 4'd0, 1'b0, 32'h0);
    xfer(1'b0, BASE + 32'h8,    32'h0,         4'hF, 4'd0, 1'b0, 32'hA5A5_5A5A);
    xfer(1'b1, BASE + 32'hFFC,  32'h600D_F00D, 4'hF, 4'd1, 1'b0, 32'h0);
    xfer(1'b0, BASE + 32'hFFC,  32'h0,         4'hF, 4'd2, 1'b0, 32'h600D_F00D);
    xfer(1'b0, BASE + 32'h0B,   32'h0,         4'h0, 4'd0, 1'b0, 32'hA5A5_5A5A);
    @(negedge clock);
    chk("ack_cnt_t4", 32'(ack_cnt), 32'd11);
    chk("err_cnt_t4", 32'(err_cnt), 32'd3);

    // Abort by dropping cyc during wait states.
    start_long_write(BASE + 32'h8, 32'h0BAD_0BAD);
    cyc = 1'b0;
    repeat (10) @(negedge clock);
    chk("ack_cnt_abort", 32'(ack_cnt), 32'd11);
    chk("err_cnt_abort", 32'(err_cnt), 32'd3);
    xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, 4'd0, 1'b0, 32'hA5A5_5A5A);

    // Reset during the wait states of a write.
    xfer(1'b1, BASE + 32'h10, 32'hCAFE_F00D, 4'hF, 4'd0, 1'b0, 32'h0);
    start_long_write(BASE + 32'h10, 32'h1234_5678);
    reset_n = 1'b0;
    cyc = 1'b0;
    #1;
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_ack_cnt", 32'(ack_cnt), 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    repeat (8) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 4'd0, 1'b0, 32'hCAFE_F00D);
    @(negedge clock);
    chk("ack_cnt_post_rst", 32'(ack_cnt), 32'd1);
    chk("err_cnt_post_rst", 32'(err_cnt), 32'd0);

    repeat (3) @(negedge clock);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
